fifo_wr_arbiter: RTL and testbench

Round-robin write-side arbiter that shares the push port of one FIFO among `N_REQ` requesters in the FIFO write clock domain. Each requester offers data with a valid/ready handshake. The arbiter grants one owner at a time, forwards the owner's beats to the FIFO while the FIFO is not full, and rotates priority after each grant ends. Burst locking, which holds one owner for several beats, is compile-time optional.

---
 rtl/fifo_arb_pkg.sv | 21 ++
 rtl/fifo_wr_arbiter_rr_picker.sv | 32 +++
 rtl/fifo_wr_arbiter.sv | 131 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-side arbiter family.
// No logic; compile-time only.
// Imported by the arbiter top and the round-robin picker.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  // Index width for an N-way selection; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter width able to hold values 0..max_burst inclusive.
  function automatic int cnt_width(input int max_burst);
    return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin search: first set bit of i_valid starting at i_ptr+1, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides when to use the result.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     i_valid,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  logic [IDX_W-1:0] cand_idx;

  // Scan farthest offset first so the nearest valid candidate after i_ptr wins.
  always_comb begin
    o_found  = 1'b0;
    o_idx    = '0;
    cand_idx = '0;
    for (int i = N; i >= 1; i--) begin
      cand_idx = IDX_W'((int'(i_ptr) + i) % N);
      if (i_valid[cand_idx]) begin
        o_found = 1'b1;
        o_idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among N_REQ valid/ready requesters.
// Latency: grant one cycle after request seen in IDLE; pushes are combinational while owned.
// Backpressure: i_fifo_full drops owner ready and push; state, owner and count hold.
// Optional burst lock under macro FIFO_WR_ARB_BURST_EN (grant lasts until last or MAX_BURST beats).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [N_REQ-1:0]       i_req_valid,
  input  logic [N_REQ*WIDTH-1:0] i_req_data,
  input  logic [N_REQ-1:0]       i_req_last,
  output logic [N_REQ-1:0]       o_req_ready,
  input  logic                   i_fifo_full,
  output logic                   o_fifo_push,
  output logic [WIDTH-1:0]       o_fifo_wdata,
  output logic [N_REQ-1:0]       o_grant,
  output logic                   o_busy
);

  localparam int IDX_W = idx_width(N_REQ);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

`ifdef FIFO_WR_ARB_BURST_EN
  localparam int CNT_W = cnt_width(MAX_BURST);
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
`else
  // Burst inputs have no meaning when every grant is a single beat.
  logic unused_burst_inputs;
  assign unused_burst_inputs = (^i_req_last) ^ (MAX_BURST > 0);
`endif

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [WIDTH-1:0] req_data_arr [N_REQ];
  logic             beat_acc;
  logic             grant_end;

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign req_data_arr[k] = i_req_data[k*WIDTH +: WIDTH];
  end

  rr_picker #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_valid (i_req_valid),
    .i_ptr   (rr_ptr_q),
    .o_found (pick_found),
    .o_idx   (pick_idx)
  );

  // Next-state and output decode; IDLE only arbitrates, OWN only transfers.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    o_req_ready  = '0;
    o_fifo_push  = 1'b0;
    o_fifo_wdata = '0;
    o_grant      = '0;
    o_busy       = 1'b0;
    beat_acc     = 1'b0;
    grant_end    = 1'b0;
`ifdef FIFO_WR_ARB_BURST_EN
    beat_cnt_d   = beat_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          state_d = ST_OWN;
`ifdef FIFO_WR_ARB_BURST_EN
          beat_cnt_d = '0;
`endif
        end
      end
      ST_OWN: begin
        o_busy               = 1'b1;
        o_grant[owner_q]     = 1'b1;
        o_req_ready[owner_q] = !i_fifo_full;
        o_fifo_wdata         = req_data_arr[owner_q];
        beat_acc             = i_req_valid[owner_q] && !i_fifo_full;
        o_fifo_push          = beat_acc;
`ifdef FIFO_WR_ARB_BURST_EN
        if (beat_acc) begin
          if (beat_cnt_q != CNT_W'(MAX_BURST)) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
          // Counter value before this beat is MAX_BURST-1 on the final allowed beat.
          grant_end = i_req_last[owner_q] || (beat_cnt_q >= CNT_W'(MAX_BURST - 1));
        end
`else
        grant_end = beat_acc;
`endif
        if (grant_end) begin
          state_d  = ST_IDLE;
          rr_ptr_d = owner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset leaves requester 0 with first priority.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= IDX_W'(N_REQ - 1);
`ifdef FIFO_WR_ARB_BURST_EN
      beat_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
`ifdef FIFO_WR_ARB_BURST_EN
      beat_cnt_q <= beat_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with hand-computed expectations.
// Works with or without FIFO_WR_ARB_BURST_EN; burst-split scenario only in the burst build.
// All inputs change 2 time units after the rising edge; outputs sampled 1 unit later.
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           i_clk = 1'b0;
  logic           i_rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic           fifo_full = 1'b0;
  logic           fifo_push;
  logic [W-1:0]   fifo_wdata;
  logic [N-1:0]   grant;
  logic           busy;

  int total = 0;
  int bad = 0;

  logic [W-1:0] beats [8];
  logic [W-1:0] plog [8];

  fifo_wr_arbiter #(
    .N_REQ     (N),
    .WIDTH     (W),
    .MAX_BURST (4)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_valid  (req_valid),
    .i_req_data   (req_data),
    .i_req_last   (req_last),
    .o_req_ready  (req_ready),
    .i_fifo_full  (fifo_full),
    .o_fifo_push  (fifo_push),
    .o_fifo_wdata (fifo_wdata),
    .o_grant      (grant),
    .o_busy       (busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic cyc();
    @(posedge i_clk);
    #2;
  endtask

  task automatic set_data(input int k, input logic [W-1:0] v);
    req_data[k*W +: W] = v;
  endtask

  task automatic do_reset();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    i_rst_n   = 1'b0;
    cyc();
    cyc();
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    i_rst_n   = 1'b0;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    #1;
    total++;
    if ({grant, busy, fifo_push, req_ready} !== 10'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=%b", {grant, busy, fifo_push, req_ready}, 10'b0);
    end
    total++;
    if (fifo_wdata !== 16'h0000) begin
      bad++;
      $display("FAIL reset_wdata got=%h exp=0000", fifo_wdata);
    end
    do_reset();
  endtask

  task automatic test_single();
    cyc();
    req_valid = 4'b0100;
    req_last  = 4'b0100;
    set_data(2, 16'h00A5);
    #1;
    total++;
    if (busy !== 1'b0 || fifo_push !== 1'b0) begin
      bad++;
      $display("FAIL single_idle busy=%b push=%b exp 0 0", busy, fifo_push);
    end
    cyc();
    #1;
    total++;
    if (grant !== 4'b0100) begin
      bad++;
      $display("FAIL single_grant got=%b exp=0100", grant);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL single_busy got=%b exp=1", busy);
    end
    total++;
    if (fifo_push !== 1'b1 || fifo_wdata !== 16'h00A5) begin
      bad++;
      $display("FAIL single_push push=%b wdata=%h exp 1 00a5", fifo_push, fifo_wdata);
    end
    total++;
    if (req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL single_ready got=%b exp=0100", req_ready);
    end
    cyc();
    req_valid = '0;
    req_last  = '0;
    #1;
    total++;
    if (busy !== 1'b0 || grant !== 4'b0000) begin
      bad++;
      $display("FAIL single_back_idle busy=%b grant=%b exp 0 0000", busy, grant);
    end
  endtask

  // Pointer is 2 after the single test, so service order starts at 3.
  task automatic test_round_robin();
    int seq [6] = '{3, 0, 1, 2, 3, 0};
    logic [W-1:0] exp_d;
    cyc();
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    for (int k = 0; k < N; k++) set_data(k, 16'h1000 + 16'(k));
    for (int n = 0; n < 12; n++) begin
      #1;
      total++;
      if (n % 2 == 0) begin
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL rr_bubble cycle=%0d busy=%b exp=0", n, busy);
        end
      end else begin
        exp_d = 16'h1000 + 16'(seq[n/2]);
        if (grant !== 4'(1 << seq[n/2]) || fifo_push !== 1'b1 || fifo_wdata !== exp_d) begin
          bad++;
          $display("FAIL rr_grant cycle=%0d grant=%b push=%b wdata=%h exp %b 1 %h",
                   n, grant, fifo_push, fifo_wdata, 4'(1 << seq[n/2]), exp_d);
        end
      end
      cyc();
    end
    req_valid = '0;
    req_last  = '0;
  endtask

  task automatic test_fifo_full();
    int idx = 0;
    int np = 0;
    do_reset();
    beats[0] = 16'hB001;
    beats[1] = 16'hB002;
    beats[2] = 16'hB003;
    for (int c = 0; c < 40 && idx < 3; c++) begin
      fifo_full    = (c >= 3 && c <= 5);
      req_valid[0] = 1'b1;
      req_last[0]  = (idx == 2);
      set_data(0, beats[idx]);
      #1;
      if (fifo_full) begin
        total++;
        if (fifo_push !== 1'b0 || req_ready !== 4'b0000) begin
          bad++;
          $display("FAIL full_block cycle=%0d push=%b ready=%b exp 0 0000", c, fifo_push, req_ready);
        end
        total++;
        if (grant !== 4'b0001) begin
          bad++;
          $display("FAIL full_hold cycle=%0d grant=%b exp=0001", c, grant);
        end
      end
      if (fifo_push === 1'b1) begin
        if (np < 8) plog[np] = fifo_wdata;
        np++;
        idx++;
      end
      cyc();
    end
    req_valid = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    total++;
    if (np !== 3) begin
      bad++;
      $display("FAIL full_count got=%0d exp=3", np);
    end
    for (int i = 0; i < 3 && i < np; i++) begin
      total++;
      if (plog[i] !== beats[i]) begin
        bad++;
        $display("FAIL full_order beat=%0d got=%h exp=%h", i, plog[i], beats[i]);
      end
    end
  endtask

  task automatic test_owner_stall();
    do_reset();
    req_valid = 4'b0010;
    req_last  = 4'b1111;
    set_data(0, 16'hC000);
    set_data(1, 16'hC001);
    set_data(2, 16'hC002);
    cyc();
    req_valid = 4'b0101;
    for (int s = 0; s < 2; s++) begin
      #1;
      total++;
      if (grant !== 4'b0010 || fifo_push !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold cycle=%0d grant=%b push=%b exp 0010 0", s, grant, fifo_push);
      end
      cyc();
    end
    req_valid = 4'b0111;
    #1;
    total++;
    if (grant !== 4'b0010 || fifo_push !== 1'b1 || fifo_wdata !== 16'hC001) begin
      bad++;
      $display("FAIL stall_resume grant=%b push=%b wdata=%h exp 0010 1 c001", grant, fifo_push, fifo_wdata);
    end
    cyc();
    req_valid = 4'b0101;
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL stall_release busy=%b exp=0", busy);
    end
    cyc();
    #1;
    total++;
    if (grant !== 4'b0100 || fifo_wdata !== 16'hC002) begin
      bad++;
      $display("FAIL stall_next grant=%b wdata=%h exp 0100 c002", grant, fifo_wdata);
    end
    cyc();
    req_valid = '0;
    req_last  = '0;
    cyc();
  endtask

  task automatic test_reset_mid_own();
    do_reset();
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    for (int k = 0; k < N; k++) set_data(k, 16'hE000 + 16'(k));
    cyc();
    cyc();
    cyc();
    #1;
    total++;
    if (grant !== 4'b0010) begin
      bad++;
      $display("FAIL rstmid_pre grant=%b exp=0010", grant);
    end
    i_rst_n = 1'b0;
    #1;
    total++;
    if ({grant, busy, fifo_push, req_ready} !== 10'b0 || fifo_wdata !== 16'h0000) begin
      bad++;
      $display("FAIL rstmid_outputs ctrl=%b wdata=%h exp all zero",
               {grant, busy, fifo_push, req_ready}, fifo_wdata);
    end
    i_rst_n = 1'b1;
    cyc();
    #1;
    total++;
    if (grant !== 4'b0001 || fifo_wdata !== 16'hE000) begin
      bad++;
      $display("FAIL rstmid_priority grant=%b wdata=%h exp 0001 e000", grant, fifo_wdata);
    end
    cyc();
    req_valid = '0;
    req_last  = '0;
    cyc();
  endtask

`ifdef FIFO_WR_ARB_BURST_EN
  task automatic test_burst_split();
    int idx = 0;
    int np = 0;
    do_reset();
    for (int i = 0; i < 6; i++) beats[i] = 16'hD101 + 16'(i);
    for (int c = 0; c < 40 && idx < 6; c++) begin
      req_valid[1] = 1'b1;
      req_last[1]  = (idx == 5);
      set_data(1, beats[idx]);
      #1;
      if (c == 5) begin
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL burst_rearb busy=%b exp=0", busy);
        end
      end
      if (c == 6) begin
        total++;
        if (grant !== 4'b0010 || fifo_push !== 1'b1) begin
          bad++;
          $display("FAIL burst_second grant=%b push=%b exp 0010 1", grant, fifo_push);
        end
      end
      if (fifo_push === 1'b1) begin
        if (np < 8) plog[np] = fifo_wdata;
        np++;
        idx++;
      end
      cyc();
    end
    req_valid = '0;
    req_last  = '0;
    total++;
    if (np !== 6) begin
      bad++;
      $display("FAIL burst_count got=%0d exp=6", np);
    end
    for (int i = 0; i < 6 && i < np; i++) begin
      total++;
      if (plog[i] !== beats[i]) begin
        bad++;
        $display("FAIL burst_order beat=%0d got=%h exp=%h", i, plog[i], beats[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fifo_full();
    test_owner_stall();
    test_reset_mid_own();
`ifdef FIFO_WR_ARB_BURST_EN
    test_burst_split();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
